// File: rtl/perf_monitor.sv
// Pipeline perf counters (cycle/stall/flush) over a bounded run, plus a valid/ready snapshot port.
// Counters and snapshot are registered (1 edge); a held snapshot drops new requests until accepted.
`timescale 1ns/1ps
module perf_monitor #(
  parameter int unsigned NUM_CYCLES = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             flush_i,
  input  logic             snap_req_i,
  input  logic             snap_ready_i,
  output logic             snap_valid_o,
  output logic [CNT_W-1:0] snap_cycle_o,
  output logic [CNT_W-1:0] snap_stall_o,
  output logic [CNT_W-1:0] snap_flush_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             done_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  typedef struct packed {
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } cnt_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(NUM_CYCLES);
  localparam logic [CNT_W-1:0] SAT   = '1;

  state_e state_q;
  cnt_t   cnt_q, cnt_d;
  cnt_t   snap_q, snap_d;
  logic   snap_vld_q, snap_vld_d;
  logic   count_en;
  logic   capture;

  assign count_en = (state_q == ST_RUN) && start_i && (cnt_q.cyc < LIMIT);
  assign capture  = snap_req_i && (!snap_vld_q || snap_ready_i);

  always_comb begin
    cnt_d = cnt_q;
    if (count_en) begin
      cnt_d.cyc = cnt_q.cyc + 1'b1;
      // a branch in the same cycle explains the stall, so it is not charged
      if (stall_i && !branch_i && (cnt_q.stall != SAT)) cnt_d.stall = cnt_q.stall + 1'b1;
      if (flush_i && (cnt_q.flush != SAT))              cnt_d.flush = cnt_q.flush + 1'b1;
    end
  end

  always_comb begin
    snap_d     = snap_q;
    snap_vld_d = snap_vld_q;
    if (capture) begin
      snap_d     = cnt_q;
      snap_vld_d = 1'b1;
    end else if (snap_vld_q && snap_ready_i) begin
      snap_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      snap_q     <= '0;
      snap_vld_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      snap_vld_q <= snap_vld_d;
      case (state_q)
        ST_IDLE: if (start_i) state_q <= ST_RUN;
        ST_RUN:  if (cnt_q.cyc == LIMIT) state_q <= ST_DONE;
        ST_DONE: state_q <= ST_DONE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done_o       = (state_q == ST_DONE);
  assign cycle_cnt_o  = cnt_q.cyc;
  assign stall_cnt_o  = cnt_q.stall;
  assign flush_cnt_o  = cnt_q.flush;
  assign snap_valid_o = snap_vld_q;
  assign snap_cycle_o = snap_q.cyc;
  assign snap_stall_o = snap_q.stall;
  assign snap_flush_o = snap_q.flush;

endmodule

// File: tb/tb_perf_monitor.sv
// Scoreboard bench for perf_monitor: random and directed stimulus against a behavioural model.
`timescale 1ns/1ps
module tb_perf_monitor;
  localparam int    N   = 64;
  localparam longint MAX = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, st, stl, br, fl, rq, rd;
  logic        sv, done;
  logic [31:0] scyc, sstl, sfl, cyc, cstl, cfl;

  logic        rst2, st2, stl2, fl2;
  logic        br2 = 1'b0, rq2 = 1'b0, rd2 = 1'b0;
  logic        sv2, done2;
  logic [3:0]  scyc2, sstl2, sfl2, cyc2, cstl2, cfl2;

  perf_monitor #(.NUM_CYCLES(N), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(st), .stall_i(stl), .branch_i(br), .flush_i(fl),
    .snap_req_i(rq), .snap_ready_i(rd), .snap_valid_o(sv),
    .snap_cycle_o(scyc), .snap_stall_o(sstl), .snap_flush_o(sfl),
    .cycle_cnt_o(cyc), .stall_cnt_o(cstl), .flush_cnt_o(cfl), .done_o(done));

  perf_monitor #(.NUM_CYCLES(15), .CNT_W(4)) dut_small (
    .clk_i(clk), .rst_i(rst2), .start_i(st2), .stall_i(stl2), .branch_i(br2), .flush_i(fl2),
    .snap_req_i(rq2), .snap_ready_i(rd2), .snap_valid_o(sv2),
    .snap_cycle_o(scyc2), .snap_stall_o(sstl2), .snap_flush_o(sfl2),
    .cycle_cnt_o(cyc2), .stall_cnt_o(cstl2), .flush_cnt_o(cfl2), .done_o(done2));

  typedef struct {
    longint cyc, stl, fl, scyc, sstl, sfl;
    bit     done, sv;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: "started" and "finished" flags plus plain integer counts.
  longint m_cyc = 0, m_stl = 0, m_fl = 0, m_scyc = 0, m_sstl = 0, m_sfl = 0;
  bit     m_started = 0, m_finished = 0, m_sv = 0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit rb(input int pct);
    return $urandom_range(99, 0) < pct;
  endfunction

  function automatic void model_step();
    exp_t e;
    if (rst) begin
      m_cyc = 0; m_stl = 0; m_fl = 0; m_scyc = 0; m_sstl = 0; m_sfl = 0;
      m_started = 0; m_finished = 0; m_sv = 0;
    end else begin
      if (rq && (!m_sv || rd)) begin
        m_scyc = m_cyc; m_sstl = m_stl; m_sfl = m_fl; m_sv = 1;
      end else if (m_sv && rd) begin
        m_sv = 0;
      end
      if (m_finished) begin
      end else if (!m_started) begin
        if (st) m_started = 1;
      end else if (m_cyc == N) begin
        m_finished = 1;
      end else if (st) begin
        m_cyc = m_cyc + 1;
        if (stl && !br) m_stl = (m_stl >= MAX) ? MAX : m_stl + 1;
        if (fl)         m_fl  = (m_fl  >= MAX) ? MAX : m_fl + 1;
      end
    end
    e.cyc = m_cyc; e.stl = m_stl; e.fl = m_fl;
    e.scyc = m_scyc; e.sstl = m_sstl; e.sfl = m_sfl;
    e.done = m_finished; e.sv = m_sv;
    exp_q.push_back(e);
  endfunction

  task automatic cyc_drv(input bit r, s, sl, b, f, q, y);
    @(negedge clk);
    rst = r; st = s; stl = sl; br = b; fl = f; rq = q; rd = y;
    model_step();
  endtask

  // Monitor: one expectation is queued per driven edge; compare right after that edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("cycle_cnt", cyc, e.cyc);
        chk("stall_cnt", cstl, e.stl);
        chk("flush_cnt", cfl, e.fl);
        chk("done", done, e.done);
        chk("snap_valid", sv, e.sv);
        chk("snap_cycle", scyc, e.scyc);
        chk("snap_stall", sstl, e.sstl);
        chk("snap_flush", sfl, e.sfl);
      end
    end
  end

  task automatic run_to_done(input int pause, output int edges);
    cyc_drv(1, 0, 0, 0, 0, 0, 0);
    edges = 0;
    for (int e = 1; e <= 300; e++) begin
      cyc_drv(0, !(e >= 20 && e < 20 + pause), rb(50), rb(25), rb(50), rb(20), rb(50));
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        edges = e;
        break;
      end
    end
  endtask

  initial begin
    int edges;
    rst = 1; st = 0; stl = 0; br = 0; fl = 0; rq = 0; rd = 0;
    rst2 = 1; st2 = 0; stl2 = 0; fl2 = 0;

    // Narrow instance: counts must top out at 15 without wrapping.
    @(negedge clk);
    @(negedge clk);
    rst2 = 0; st2 = 1; stl2 = 1; fl2 = 1;
    repeat (20) @(negedge clk);
    chk("small_stall_sat", cstl2, 15);
    chk("small_flush_sat", cfl2, 15);
    chk("small_cycle", cyc2, 15);
    chk("small_done", done2, 1);

    // Reset, then the stall/branch/flush mix.
    cyc_drv(1, 0, 0, 0, 0, 0, 0);
    cyc_drv(1, 1, 1, 0, 1, 0, 0);
    cyc_drv(0, 1, 0, 0, 0, 0, 0);
    repeat (3) cyc_drv(0, 1, 1, 0, 0, 0, 0);
    cyc_drv(0, 1, 1, 1, 0, 0, 0);
    repeat (2) cyc_drv(0, 1, 0, 0, 1, 0, 0);
    @(posedge clk);
    #2;
    chk("mix_stall", cstl, 3);
    chk("mix_flush", cfl, 2);
    chk("mix_cycle", cyc, 6);

    // Full run: start edge + 64 counting edges + transition edge.
    run_to_done(0, edges);
    chk("done_edge_nopause", edges, 66);
    repeat (10) cyc_drv(0, rb(50), 1, 0, 1, 0, 0);
    @(posedge clk);
    #2;
    chk("done_sticky_cycle", cyc, 64);
    chk("done_sticky", done, 1);

    run_to_done(5, edges);
    chk("done_edge_pause5", edges, 71);

    // Snapshot held while not ready; second request dropped; accept+request recaptures.
    cyc_drv(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40 && m_cyc < 13; i++)
      cyc_drv(0, 1, 0, 0, 0, (m_cyc == 7 || m_cyc == 9 || m_cyc == 11), (m_cyc == 11));
    @(posedge clk);
    #2;
    chk("snap_recapture", scyc, 11);
    chk("snap_recapture_vld", sv, 1);

    // Reset mid-run with a snapshot pending.
    cyc_drv(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 100 && m_cyc != 30; i++)
      cyc_drv(0, 1, rb(50), 0, rb(50), (m_cyc == 28), 0);
    cyc_drv(1, 1, 1, 0, 1, 1, 1);
    @(posedge clk);
    #2;
    chk("rst_cycle", cyc, 0);
    chk("rst_snap_vld", sv, 0);
    chk("rst_done", done, 0);
    cyc_drv(0, 1, 1, 0, 1, 0, 0);

    // Random traffic with occasional resets.
    for (int r = 0; r < 6; r++) begin
      cyc_drv(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 150; i++)
        cyc_drv(rb(2), rb(85), rb(50), rb(25), rb(35), rb(30), rb(50));
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 Parameter NUM_CYCLES, default 64, number of counted run cycles before the run completes.
REQ-002 Parameter CNT_W, default 32, width of every counter and snapshot output.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 start_i  input  1  run enable from the CPU start signal.
REQ-006 stall_i  input  1  hazard-detection stall indication.
REQ-007 branch_i  input  1  control-unit branch indication; masks stall_i when high.
REQ-008 flush_i  input  1  branch-unit flush indication.
REQ-009 snap_req_i  input  1  request to capture current counter values.
REQ-010 snap_ready_i  input  1  consumer accepts the presented snapshot.
REQ-011 snap_valid_o  output  1  snapshot outputs hold a valid, stable capture.
REQ-012 snap_cycle_o / snap_stall_o / snap_flush_o  output  CNT_W each  captured cycle, stall and flush counts.
REQ-013 cycle_cnt_o / stall_cnt_o / flush_cnt_o  output  CNT_W each  live counter registers.
REQ-014 done_o  output  1  run complete; high only in state DONE.

Function
REQ-015 FSM states IDLE, RUN, DONE; encoding free; done_o shall be a decode of DONE.
REQ-016 IDLE -> RUN on a rising edge with start_i=1; no counting occurs on that edge.
REQ-017 In RUN, on an edge with start_i=1 and cycle_cnt_o < NUM_CYCLES: cycle_cnt_o +1; stall_cnt_o +1 iff stall_i=1 and branch_i=0; flush_cnt_o +1 iff flush_i=1.
REQ-018 In RUN with start_i=0, all counters shall hold (pause); state stays RUN.
REQ-019 In RUN, on an edge where cycle_cnt_o == NUM_CYCLES, state -> DONE, counters hold; done_o=1 from the following cycle.
REQ-020 DONE is sticky until rst_i; stall_i, flush_i, start_i and branch_i shall be ignored in DONE.
REQ-021 Counter outputs are registered: an input sampled at edge N is reflected on the outputs after edge N.
REQ-022 stall_cnt_o and flush_cnt_o shall saturate at 2^CNT_W-1, never wrap; cycle_cnt_o is bounded by NUM_CYCLES (NUM_CYCLES shall be <= 2^CNT_W-1).
REQ-023 Capture occurs on an edge with snap_req_i=1 and (snap_valid_o=0 or snap_ready_i=1): snap_* take the counter register values present before that edge; snap_valid_o=1 after the edge.
REQ-024 While snap_valid_o=1 and snap_ready_i=0, snap_* shall stay stable and snap_req_i shall be ignored (request dropped, not queued).
REQ-025 On snap_valid_o=1, snap_ready_i=1, snap_req_i=0, snap_valid_o -> 0; snap_* values may hold.
REQ-026 Simultaneous accept and request (valid=1, ready=1, req=1) shall recapture in the same edge with snap_valid_o staying 1.
REQ-027 Snapshots shall operate in all FSM states, including IDLE and DONE.

Reset
REQ-028 On an edge with rst_i=1: state IDLE; all counters 0; snap_valid_o=0; snap_* 0; done_o=0.
REQ-029 rst_i shall take priority over every other input, including mid-RUN and during a pending snapshot.

Verification
REQ-030 Reset, start_i=1 held, 3 cycles stall_i=1/branch_i=0, 1 cycle stall_i=1/branch_i=1, 2 cycles flush_i=1 -> stall_cnt_o=3, flush_cnt_o=2, cycle_cnt_o equals the counted edges.
REQ-031 NUM_CYCLES=64, start_i held -> cycle_cnt_o=64, done_o=1 one cycle later; 10 further stall/flush pulses leave all counters unchanged.
REQ-032 start_i dropped for 5 cycles mid-RUN -> counters frozen for those 5 cycles; counting resumes on start_i=1; done reached 5 cycles later than the unpaused run.
REQ-033 CNT_W=4, NUM_CYCLES=15, stall_i=1 and flush_i=1 held for 20 edges -> stall_cnt_o=flush_cnt_o=15, no wrap to 0.
REQ-034 snap_req_i at cycle_cnt_o=7 with snap_ready_i=0 for 4 cycles, second req at cycle_cnt_o=9 -> snap_cycle_o stays 7; ready+req together at cycle_cnt_o=11 -> snap_cycle_o=11, snap_valid_o stays 1.
REQ-035 rst_i=1 at cycle_cnt_o=30 with snap_valid_o=1 -> next cycle all counters 0, snap_valid_o=0, state IDLE, done_o=0.
